// File: rtl/gcd_datapath.sv
// +----------------------------------------------------------------------------+
// | gcd_datapath: GCD operand registers, subtract step, compare status and     |
// | result capture. Optional iteration counter enabled by GCD_ITER_CNT_EN.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module gcd_datapath #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_A,
  input  logic             load_B,
  input  logic             s_in1,
  input  logic             s_in2,
  input  logic             s_in3,
  input  logic             done,
  output logic             EQ,
  output logic             LT,
  output logic             GT,
  output logic [WIDTH-1:0] res_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             zero_err,
  output logic             overrun,
  output logic [CNT_W-1:0] iter_cnt
);

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sub;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_valid_q, res_valid_d;
  logic             zero_err_q, zero_err_d;
  logic             overrun_q, overrun_d;
  logic             done_q, done_d;
  logic             done_rise, pop;

  always_comb begin
    // s_in1 has priority; s_in2 alone and neither-set both select A-B
    sub = s_in1 ? (b_q - a_q) : (a_q - b_q);
    if (s_in2) sub = s_in1 ? (b_q - a_q) : (a_q - b_q);

    a_d = a_q;
    b_d = b_q;
    if (load_A) a_d = s_in3 ? data_in : sub;
    if (load_B) b_d = s_in3 ? data_in : sub;

    zero_err_d = zero_err_q |
                 (s_in3 & (load_A | load_B) & (data_in == {WIDTH{1'b0}}));

    done_d    = done;
    done_rise = done & ~done_q;
    pop       = res_valid_q & res_ready;

    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    overrun_d   = overrun_q;
    if (done_rise) begin
      if (!res_valid_q || pop) begin
        res_data_d  = a_q;
        res_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (pop) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_q         <= '0;
      b_q         <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      zero_err_q  <= 1'b0;
      overrun_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      zero_err_q  <= zero_err_d;
      overrun_q   <= overrun_d;
      done_q      <= done_d;
    end
  end

  assign EQ        = (a_q == b_q);
  assign LT        = (a_q <  b_q);
  assign GT        = (a_q >  b_q);
  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;
  assign zero_err  = zero_err_q;
  assign overrun   = overrun_q;

`ifdef GCD_ITER_CNT_EN
  logic [CNT_W-1:0] iter_cnt_q, iter_cnt_d;

  // A fresh A operand starts a new problem; subtract steps saturate
  always_comb begin
    iter_cnt_d = iter_cnt_q;
    if (load_A && s_in3)
      iter_cnt_d = '0;
    else if ((load_A || load_B) && !s_in3 && (iter_cnt_q != {CNT_W{1'b1}}))
      iter_cnt_d = iter_cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) iter_cnt_q <= '0;
    else       iter_cnt_q <= iter_cnt_d;
  end

  assign iter_cnt = iter_cnt_q;
`else
  assign iter_cnt = {CNT_W{1'b0}};
`endif

endmodule

`default_nettype wire

// File: tb/tb_gcd_datapath.sv
// Scoreboarded bench for gcd_datapath: directed GCD problems, handshake,
// overrun, zero-operand and reset cases; a second instance uses CNT_W=2.
`default_nettype none

module tb_gcd_datapath;

`ifdef GCD_ITER_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        i_rst;
  logic [15:0] data_in;
  logic        load_A, load_B, s_in1, s_in2, s_in3, done, res_ready;
  logic        EQ, LT, GT, res_valid, zero_err, overrun;
  logic [15:0] res_data, iter_cnt;
  logic        EQ2, LT2, GT2, res_valid2, zero_err2, overrun2;
  logic [15:0] res_data2;
  logic [1:0]  iter_cnt2;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  gcd_datapath #(.WIDTH(16), .CNT_W(16)) u_dut (
    .i_clk(clk), .i_rst(i_rst), .data_in(data_in),
    .load_A(load_A), .load_B(load_B), .s_in1(s_in1), .s_in2(s_in2),
    .s_in3(s_in3), .done(done), .EQ(EQ), .LT(LT), .GT(GT),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .zero_err(zero_err), .overrun(overrun), .iter_cnt(iter_cnt)
  );

  gcd_datapath #(.WIDTH(16), .CNT_W(2)) u_sat (
    .i_clk(clk), .i_rst(i_rst), .data_in(data_in),
    .load_A(load_A), .load_B(load_B), .s_in1(s_in1), .s_in2(s_in2),
    .s_in3(s_in3), .done(done), .EQ(EQ2), .LT(LT2), .GT(GT2),
    .res_data(res_data2), .res_valid(res_valid2), .res_ready(res_ready),
    .zero_err(zero_err2), .overrun(overrun2), .iter_cnt(iter_cnt2)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic la, lb, s1, s2, s3, input logic [15:0] d);
    load_A = la; load_B = lb; s_in1 = s1; s_in2 = s2; s_in3 = s3; data_in = d;
    tick();
    load_A = 1'b0; load_B = 1'b0; s_in1 = 1'b0; s_in2 = 1'b0; s_in3 = 1'b0;
  endtask

  task automatic load_a(input logic [15:0] v); drive(1, 0, 0, 0, 1, v); endtask
  task automatic load_b(input logic [15:0] v); drive(0, 1, 0, 0, 1, v); endtask
  task automatic sub_a();  drive(1, 0, 0, 1, 0, 16'h0); endtask  // A <= A-B
  task automatic sub_b();  drive(0, 1, 1, 0, 0, 16'h0); endtask  // B <= B-A

  // Monitor: every accepted result must match the oldest expected result
  always @(negedge clk) begin
    if (!i_rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", {16'h0, res_data}, 32'hdead_beef);
      end else begin
        chk("result", {16'h0, res_data}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; data_in = 16'h1234; load_A = 1'b1; load_B = 1'b1;
    s_in1 = 1'b1; s_in2 = 1'b1; s_in3 = 1'b1; done = 1'b1; res_ready = 1'b1;
    tick(); tick();
    load_A = 0; load_B = 0; s_in1 = 0; s_in2 = 0; s_in3 = 0; done = 0; res_ready = 0;
    tick();
    i_rst = 1'b0;
    chk("rst_cmp", {EQ, LT, GT}, 3'b100);
    chk("rst_flags", {res_valid, zero_err, overrun}, 3'b000);
    chk("rst_data", res_data, 0);
    chk("rst_iter", iter_cnt, 0);

    // GCD(48,18), result held with res_ready low
    load_a(48); load_b(18);
    chk("g48_cmp0", {EQ, LT, GT}, 3'b001);
    sub_a(); chk("g48_cmp1", {EQ, LT, GT}, 3'b001);  // A=30
    sub_a(); chk("g48_cmp2", {EQ, LT, GT}, 3'b010);  // A=12
    sub_b(); chk("g48_cmp3", {EQ, LT, GT}, 3'b001);  // B=6
    sub_a(); chk("g48_cmp4", {EQ, LT, GT}, 3'b100);  // A=6
    done = 1'b1; exp_q.push_back(16'd6);
    tick();
    chk("g48_valid", res_valid, 1);
    chk("g48_data", res_data, 6);
    chk("g48_iter", iter_cnt, CNT_EN ? 4 : 0);
    chk("g48_iter_sat", iter_cnt2, CNT_EN ? 3 : 0);
    tick();
    chk("g48_hold", {res_valid, overrun, res_data}, {2'b10, 16'd6});

    // Overrun: second result arrives while 6 still unpopped
    done = 1'b0; tick();
    load_a(9); load_b(9);
    chk("g9_cmp", {EQ, LT, GT}, 3'b100);
    done = 1'b1; tick();
    chk("ovr_set", {res_valid, overrun, res_data}, {2'b11, 16'd6});
    done = 1'b0; tick();
    chk("ovr_sticky", overrun, 1);
    // Pop and capture in the same cycle: capture wins
    done = 1'b1; res_ready = 1'b1; exp_q.push_back(16'd9);
    tick();
    chk("popcap", {res_valid, overrun, res_data}, {2'b11, 16'd9});
    tick();
    chk("popcap_drain", res_valid, 0);
    done = 1'b0; tick();

    // GCD(17,5) with res_ready high
    load_a(17); load_b(5);
    sub_a(); sub_a(); sub_a();  // A=12,7,2
    sub_b(); sub_b();           // B=3,1
    sub_a();                    // A=1
    chk("g17_cmp", {EQ, LT, GT}, 3'b100);
    done = 1'b1; exp_q.push_back(16'd1);
    tick();
    chk("g17_valid", {res_valid, res_data}, {1'b1, 16'd1});
    chk("g17_iter", iter_cnt, CNT_EN ? 6 : 0);
    chk("g17_iter_sat", iter_cnt2, CNT_EN ? 3 : 0);
    tick();
    chk("g17_one_cycle", res_valid, 0);
    done = 1'b0; tick();
    chk("zero_pre", zero_err, 0);

    // Zero operand flag is sticky
    load_a(0);
    chk("zero_set", zero_err, 1);
    load_b(7);
    chk("zero_cmp", {EQ, LT, GT}, 3'b010);
    load_a(5); load_b(5); sub_a(); load_a(5);
    chk("zero_sticky", zero_err, 1);

    // Reset mid-problem discards a pending result
    res_ready = 1'b0;
    load_a(20); load_b(6); sub_a();  // A=14
    done = 1'b1; tick();
    chk("pend_cap", {res_valid, res_data}, {1'b1, 16'd14});
    i_rst = 1'b1; tick();
    chk("mid_rst_cmp", {EQ, LT, GT}, 3'b100);
    chk("mid_rst_flags", {res_valid, zero_err, overrun}, 3'b000);
    chk("mid_rst_data", res_data, 0);
    chk("mid_rst_iter", {iter_cnt, 14'h0, iter_cnt2}, 0);
    done = 1'b0; i_rst = 1'b0; tick();
    chk("mid_rst_after", res_valid, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
